// File: rtl/io_stream_module_if.sv
// Handshake bundle between the cube colour streamer and its software/engine peer.
// The slave modport is the streamer side; master is the peer driving to_hw_sig/ready.
interface io_stream_module_if #(
   parameter int DATA_W    = 30,
   parameter int NUM_CELLS = 9,
   parameter int NUM_FACES = 6
);
   localparam int FACE_W = (NUM_FACES > 1) ? $clog2(NUM_FACES) : 1;

   logic                        ready;
   logic [1:0]                  to_hw_sig;
   logic [NUM_CELLS*DATA_W-1:0] Colors;
   logic [DATA_W-1:0]           to_sw_port;
   logic [1:0]                  to_sw_sig;
   logic [FACE_W-1:0]           Face_idx;
   logic                        Face_done;
   logic                        All_done;
   logic                        Timeout_err;

   modport master (
      output ready, to_hw_sig, Colors,
      input  to_sw_port, to_sw_sig, Face_idx, Face_done, All_done, Timeout_err
   );

   modport slave (
      input  ready, to_hw_sig, Colors,
      output to_sw_port, to_sw_sig, Face_idx, Face_done, All_done, Timeout_err
   );
endinterface

// File: rtl/io_stream_module.sv
// Streams a snapshot of one cube face, cell by cell, to software over a 2-bit
// handshake, with per-face/per-scan completion pulses and an optional stall timeout.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// INIT        | one cycle after reset, then WAIT
// WAIT        | idle, waiting for software start code (3)
// SEND_RUBIK  | requesting the engine, waiting for ready
// GET_RUBIK   | engine ready, waiting for software to take the face (1)
// SEND_CELL   | presenting snapshot cell[cell_idx], waiting for ack (2)
// ACK_CELL    | cell acknowledged, waiting for next-cell request (1)
// ERROR       | handshake stalled too long, waiting for clear code (0)
module io_stream_module #(
   parameter int DATA_W      = 30,
   parameter int NUM_CELLS   = 9,
   parameter int NUM_FACES   = 6,
   parameter int TIMEOUT_CYC = 0
) (
   input  logic              Clk,
   input  logic              Reset_n,
   io_stream_module_if.slave bus
);
   localparam int FACE_W = (NUM_FACES > 1) ? $clog2(NUM_FACES) : 1;
   localparam int CELL_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
   localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [FACE_W-1:0] FACE_LAST = FACE_W'(NUM_FACES - 1);
   localparam logic [CELL_W-1:0] CELL_LAST = CELL_W'(NUM_CELLS - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   typedef enum logic [2:0] {
      ST_INIT,
      ST_WAIT,
      ST_SEND_RUBIK,
      ST_GET_RUBIK,
      ST_SEND_CELL,
      ST_ACK_CELL,
      ST_ERROR
   } state_t;

   state_t                      state;
   logic [CELL_W-1:0]           cell_idx;
   logic [FACE_W-1:0]           face_idx;
   logic [TO_W-1:0]             to_cnt;
   logic [NUM_CELLS*DATA_W-1:0] snap;
   logic                        face_done;
   logic                        all_done;

   logic adv;
   logic timed;
   logic to_hit;

   always_comb begin
      adv   = 1'b0;
      timed = 1'b0;
      case (state)
         ST_INIT:       adv = 1'b1;
         ST_WAIT:       adv = (bus.to_hw_sig == 2'd3);
         ST_SEND_RUBIK: begin adv = bus.ready;               timed = 1'b1; end
         ST_GET_RUBIK:  begin adv = (bus.to_hw_sig == 2'd1); timed = 1'b1; end
         ST_SEND_CELL:  begin adv = (bus.to_hw_sig == 2'd2); timed = 1'b1; end
         ST_ACK_CELL:   begin adv = (bus.to_hw_sig == 2'd1); timed = 1'b1; end
         ST_ERROR:      adv = (bus.to_hw_sig == 2'd0);
         default:       adv = 1'b1;
      endcase
      // a real transition in the terminal cycle takes precedence over the timeout
      to_hit = (TIMEOUT_CYC != 0) && timed && !adv && (to_cnt == TO_LAST);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= ST_INIT;
         cell_idx  <= '0;
         face_idx  <= '0;
         to_cnt    <= '0;
         snap      <= '0;
         face_done <= 1'b0;
         all_done  <= 1'b0;
      end else begin
         face_done <= 1'b0;
         all_done  <= 1'b0;

         if (!timed || adv || to_hit) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end

         if (to_hit) begin
            state <= ST_ERROR;
         end else if (adv) begin
            case (state)
               ST_INIT:       state <= ST_WAIT;
               ST_WAIT:       state <= ST_SEND_RUBIK;
               ST_SEND_RUBIK: state <= ST_GET_RUBIK;
               ST_GET_RUBIK: begin
                  state    <= ST_SEND_CELL;
                  snap     <= bus.Colors;
                  cell_idx <= '0;
               end
               ST_SEND_CELL:  state <= ST_ACK_CELL;
               ST_ACK_CELL: begin
                  if (cell_idx == CELL_LAST) begin
                     state     <= ST_WAIT;
                     face_done <= 1'b1;
                     all_done  <= (face_idx == FACE_LAST);
                     face_idx  <= (face_idx == FACE_LAST) ? '0 : face_idx + 1'b1;
                  end else begin
                     state    <= ST_SEND_CELL;
                     cell_idx <= cell_idx + 1'b1;
                  end
               end
               ST_ERROR:      state <= ST_WAIT;
               default:       state <= ST_INIT;
            endcase
         end
      end
   end

   always_comb begin
      bus.to_sw_sig  = 2'd3;
      bus.to_sw_port = '0;
      case (state)
         ST_INIT:       bus.to_sw_sig = 2'd3;
         ST_WAIT:       bus.to_sw_sig = 2'd0;
         ST_SEND_RUBIK: bus.to_sw_sig = 2'd1;
         ST_GET_RUBIK:  bus.to_sw_sig = 2'd2;
         ST_SEND_CELL: begin
            bus.to_sw_sig  = 2'd1;
            bus.to_sw_port = snap[int'(cell_idx)*DATA_W +: DATA_W];
         end
         ST_ACK_CELL:   bus.to_sw_sig = 2'd0;
         ST_ERROR:      bus.to_sw_sig = 2'd3;
         default:       bus.to_sw_sig = 2'd3;
      endcase
   end

   assign bus.Face_idx    = face_idx;
   assign bus.Face_done   = face_done;
   assign bus.All_done    = all_done;
   assign bus.Timeout_err = (state == ST_ERROR);
endmodule

// File: doc/io_stream_module.md
IO_STREAM_MODULE -- requirements
Module: io_stream_module

Interface
REQ-001 SHALL have parameter DATA_W, default 30, giving the width of one cell colour word.
REQ-002 SHALL have parameter NUM_CELLS, default 9, giving the number of cells sent per face (legal 1..64).
REQ-003 SHALL have parameter NUM_FACES, default 6, giving the number of faces per full cube scan (legal 1..16).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 0, giving handshake timeout in Clk cycles; 0 disables the timeout.
REQ-005 SHALL have port Clk, input, 1 bit: the single clock; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port Reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port ready, input, 1 bit: Rubik engine has accepted the face.
REQ-008 SHALL have port to_hw_sig, input, 2 bits: software-to-hardware handshake code.
REQ-009 SHALL have port Colors, input, NUM_CELLS*DATA_W bits: cell k occupies bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port to_sw_port, output, DATA_W bits: cell word presented to software.
REQ-011 SHALL have port to_sw_sig, output, 2 bits: hardware-to-software handshake code.
REQ-012 SHALL have port Face_idx, output, clog2(NUM_FACES) bits (minimum 1): index of the face being or next to be sent.
REQ-013 SHALL have port Face_done, output, 1 bit: one-cycle pulse when a face completes.
REQ-014 SHALL have port All_done, output, 1 bit: one-cycle pulse when face NUM_FACES-1 completes.
REQ-015 SHALL have port Timeout_err, output, 1 bit: high while in ERROR.

Function
REQ-016 SHALL implement the states INIT, WAIT, SEND_RUBIK, GET_RUBIK, SEND_CELL, ACK_CELL and ERROR; all outputs SHALL be Moore, decoded from registered state, counters and the snapshot.
REQ-017 SHALL leave INIT for WAIT unconditionally after exactly one cycle.
REQ-018 SHALL go from WAIT to SEND_RUBIK when to_hw_sig==3.
REQ-019 SHALL go from SEND_RUBIK to GET_RUBIK when ready==1.
REQ-020 SHALL go from GET_RUBIK to SEND_CELL when to_hw_sig==1, and on that same edge SHALL load all of Colors into an internal snapshot register and clear cell_idx to 0.
REQ-021 SHALL go from SEND_CELL to ACK_CELL when to_hw_sig==2.
REQ-022 SHALL, in ACK_CELL with to_hw_sig==1, go to SEND_CELL with cell_idx+1 if cell_idx<NUM_CELLS-1, otherwise go to WAIT.
REQ-023 SHALL drive to_sw_sig as 3 in INIT and ERROR, 0 in WAIT and ACK_CELL, 1 in SEND_RUBIK and SEND_CELL, and 2 in GET_RUBIK.
REQ-024 SHALL drive to_sw_port with snapshot cell[cell_idx] in SEND_CELL and 0 in every other state; Colors changing after the load SHALL NOT affect transmitted data.
REQ-025 SHALL, on the last-cell ACK_CELL->WAIT edge, register Face_done=1 for exactly the next cycle and advance Face_idx modulo NUM_FACES.
REQ-026 SHALL also pulse All_done in that same cycle when the advance wraps Face_idx from NUM_FACES-1 to 0.
REQ-027 SHALL keep a timeout counter that clears on every state change and increments each cycle in SEND_RUBIK, GET_RUBIK, SEND_CELL and ACK_CELL; WAIT, INIT and ERROR SHALL never time out.
REQ-028 SHALL, when TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1 with no transition condition true, enter ERROR on the next edge; a transition condition true in that same cycle SHALL win over the timeout.
REQ-029 SHALL leave ERROR for WAIT when to_hw_sig==0; Face_idx SHALL be unchanged and the interrupted face SHALL be resent from cell 0.
REQ-030 SHALL ignore all other to_hw_sig values and SHALL ignore ready outside SEND_RUBIK.

Reset
REQ-031 SHALL, while Reset_n==0 and asynchronously, force state=INIT, cell_idx=0, Face_idx=0, timeout counter=0 and snapshot=0, giving outputs to_sw_sig=3, to_sw_port=0, Face_done=0, All_done=0 and Timeout_err=0.
REQ-032 SHALL abandon any transfer in progress when reset is asserted mid-operation, with no Face_done pulse.

Verification
REQ-033 SHALL be verified by a single-face test: defaults, cell k=k+1, full handshake -> to_sw_port shows 1..9 in order, one Face_done pulse, Face_idx goes 0->1, All_done stays 0.
REQ-034 SHALL be verified by a wrap test: NUM_FACES=2, two complete faces -> the second completion pulses Face_done and All_done together and Face_idx returns to 0.
REQ-035 SHALL be verified by a snapshot test: change Colors during cell 3 -> cells 3..9 still carry the values loaded at the GET_RUBIK->SEND_CELL edge.
REQ-036 SHALL be verified by a timeout test: TIMEOUT_CYC=16, stall in ACK_CELL on cell 5 -> ERROR after 16 cycles with Timeout_err=1 and to_sw_sig=3; then to_hw_sig=0 -> WAIT, and a restart resends from cell 1 with the same Face_idx.
REQ-037 SHALL be verified by a mid-operation reset test: drop Reset_n in SEND_CELL cell 4 -> outputs take reset values immediately, one cycle of INIT follows release, then WAIT.
REQ-038 SHALL be verified by a NUM_CELLS=1 test: DATA_W=8, one-cell face -> one SEND_CELL/ACK_CELL pair, then WAIT with a Face_done pulse.
